// File: rtl/sa_tag_array.sv
// sa_tag_array -- N-way set-associative tag store for sa_cache.
//
// Purpose:
//   Holds tag / valid / dirty per way per set plus per-set replacement
//   state. A LOOKUP is registered: it is accepted in cycle N and its
//   hit/way/victim result is presented in cycle N+1 for one cycle. FILL,
//   SET_DIRTY and INVALIDATE update the set at the end of their accept cycle.
//   After reset an INIT sweep clears one set per cycle; requests are refused
//   until the sweep has finished.
//
// Configuration:
//   SA_TAG_PLRU_EN  undefined (default): per-set round-robin pointer, moved
//                   only by FILL to (req_way+1) mod WAYS.
//                   defined: per-set tree pseudo-LRU (WAYS-1 bits), touched
//                   by LOOKUP hits and FILLs.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   req_valid/ready    request handshake (ready is low during INIT)
//   req_op             00 LOOKUP, 01 FILL, 10 SET_DIRTY, 11 INVALIDATE
//   req_index/tag/way  set index, tag (LOOKUP/FILL), target way (updates)
//   req_dirty          dirty value written by FILL
//   rsp_valid          one-cycle LOOKUP result strobe
//   rsp_hit/way/dirty  hit flag, hitting way, its dirty bit (0 on miss)
//   rsp_victim_*       replacement candidate: way, valid, dirty, tag
module sa_tag_array #(
  parameter int WAYS  = 4,
  parameter int SETS  = 1024,
  parameter int TAG_W = 18,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [IDX_W-1:0] req_index,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [WAY_W-1:0] req_way,
  input  logic             req_dirty,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic             rsp_dirty,
  output logic [WAY_W-1:0] rsp_victim_way,
  output logic             rsp_victim_valid,
  output logic             rsp_victim_dirty,
  output logic [TAG_W-1:0] rsp_victim_tag
);

  typedef enum logic [1:0] {
    OP_LOOKUP     = 2'b00,
    OP_FILL       = 2'b01,
    OP_SET_DIRTY  = 2'b10,
    OP_INVALIDATE = 2'b11
  } op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

`ifdef SA_TAG_PLRU_EN
  localparam int REPL_W = WAYS - 1;

  // Tree nodes are heap-numbered 1..WAYS-1 and stored at bit (node-1).
  // A node bit of 0 points to the lower half, 1 to the upper half.
  function automatic logic [REPL_W-1:0] plru_touch(
    input logic [REPL_W-1:0] s,
    input logic [WAY_W-1:0]  way
  );
    logic [REPL_W-1:0] t;
    int node;
    t    = s;
    node = 1;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      // Point the node away from the half that holds the touched way.
      t[node-1] = ~way[l];
      node      = 2 * node + int'(way[l]);
    end
    return t;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [REPL_W-1:0] s);
    int node;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      node = 2 * node + int'(s[node-1]);
    end
    return WAY_W'(node - WAYS);
  endfunction
`else
  localparam int REPL_W = WAY_W;
`endif

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  state_e           r_state;
  logic             r_ready;
  logic [IDX_W-1:0] r_init_idx;
  logic             r_rsp_valid;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;

  op_e  w_op;
  logic w_accept;
  logic w_lookup;
  logic w_fill;
  logic w_set_dirty;
  logic w_inval;

  assign w_op        = op_e'(req_op);
  assign w_accept    = req_valid & r_ready;
  assign w_lookup    = w_accept & (w_op == OP_LOOKUP);
  assign w_fill      = w_accept & (w_op == OP_FILL);
  assign w_set_dirty = w_accept & (w_op == OP_SET_DIRTY);
  assign w_inval     = w_accept & (w_op == OP_INVALIDATE);

  // ---------------------------------------------------------------------------
  // Control FSM: INIT sweep, then RUN. Also captures the lookup in flight.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values no matter how the statements are ordered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_ready     <= 1'b0;
      r_init_idx  <= '0;
      r_rsp_valid <= 1'b0;
      r_idx       <= '0;
      r_tag       <= '0;
    end else begin
      r_rsp_valid <= w_lookup;
      if (w_lookup) begin
        r_idx <= req_index;
        r_tag <= req_tag;
      end
      case (r_state)
        ST_INIT: begin
          r_init_idx <= r_init_idx + 1'b1;
          if (r_init_idx == IDX_W'(SETS - 1)) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_ready;

  // ---------------------------------------------------------------------------
  // Tag RAMs: one synchronous-read RAM per way, read only by LOOKUP.
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0] w_tag_q [WAYS];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    logic [TAG_W-1:0] r_mem [SETS];
    logic [TAG_W-1:0] r_q;

    // NOTE: storage arrays carry no reset; stale tags are harmless because the
    // valid flops gate every use of them, so this can map onto a plain RAM.
    always_ff @(posedge clk) begin
      if (w_fill && (req_way == WAY_W'(g))) begin
        r_mem[req_index] <= req_tag;
      end
      if (w_lookup) begin
        r_q <= r_mem[req_index];
      end
    end

    assign w_tag_q[g] = r_q;
  end

  // ---------------------------------------------------------------------------
  // Valid / dirty / replacement state, kept in flops so the INIT sweep and
  // single-bit updates need no read-modify-write of the tag RAMs.
  // ---------------------------------------------------------------------------
  logic [WAYS-1:0]   r_valid [SETS];
  logic [WAYS-1:0]   r_dirty [SETS];
  logic [REPL_W-1:0] r_repl  [SETS];

  logic [WAYS-1:0]   w_set_valid;
  logic [WAYS-1:0]   w_set_dirty_bits;
  logic [REPL_W-1:0] w_repl_cur;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic              w_inv_found;
  logic [WAY_W-1:0]  w_inv_way;
  logic [WAY_W-1:0]  w_repl_victim;
  logic [WAY_W-1:0]  w_victim_way;

  // These flops only change at the end of the response cycle, so during
  // cycle N+1 they still hold the set exactly as the tag RAM read saw it.
  assign w_set_valid      = r_valid[r_idx];
  assign w_set_dirty_bits = r_dirty[r_idx];
  assign w_repl_cur       = r_repl[r_idx];

  // NOTE: every signal driven here gets a default before any condition, so no
  // latch can be inferred.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    // Scan high to low so the lowest matching / invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_set_valid[w] && (w_tag_q[w] == r_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!w_set_valid[w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
  end

`ifdef SA_TAG_PLRU_EN
  assign w_repl_victim = plru_victim(w_repl_cur);
`else
  assign w_repl_victim = w_repl_cur;
`endif

  assign w_victim_way = w_inv_found ? w_inv_way : w_repl_victim;

`ifdef SA_TAG_PLRU_EN
  logic              w_hit_upd;
  logic [REPL_W-1:0] w_fill_base;

  assign w_hit_upd = r_rsp_valid & w_hit;
  // A FILL to the set whose hit update lands in the same cycle must build
  // on top of that update rather than on the stale tree.
  assign w_fill_base = (w_hit_upd && (r_idx == req_index))
                       ? plru_touch(w_repl_cur, w_hit_way)
                       : r_repl[req_index];
`endif

  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_valid[r_init_idx] <= '0;
      r_dirty[r_init_idx] <= '0;
      r_repl[r_init_idx]  <= '0;
    end else begin
      if (w_fill) begin
        r_valid[req_index][req_way] <= 1'b1;
        r_dirty[req_index][req_way] <= req_dirty;
      end
      if (w_set_dirty) begin
        r_dirty[req_index][req_way] <= 1'b1;
      end
      if (w_inval) begin
        r_valid[req_index][req_way] <= 1'b0;
        r_dirty[req_index][req_way] <= 1'b0;
      end
`ifdef SA_TAG_PLRU_EN
      if (w_hit_upd) begin
        r_repl[r_idx] <= plru_touch(w_repl_cur, w_hit_way);
      end
      if (w_fill) begin
        r_repl[req_index] <= plru_touch(w_fill_base, req_way);
      end
`else
      // WAY_W-bit add wraps WAYS-1 back to 0 because WAYS is a power of two.
      if (w_fill) begin
        r_repl[req_index] <= req_way + 1'b1;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Response: gated by the registered strobe so every field is 0 outside the
  // one-cycle result window (and in reset).
  // ---------------------------------------------------------------------------
  assign rsp_valid        = r_rsp_valid;
  assign rsp_hit          = r_rsp_valid & w_hit;
  assign rsp_way          = r_rsp_valid ? w_hit_way : '0;
  assign rsp_dirty        = r_rsp_valid & w_hit & w_set_dirty_bits[w_hit_way];
  assign rsp_victim_way   = r_rsp_valid ? w_victim_way : '0;
  assign rsp_victim_valid = r_rsp_valid & ~w_inv_found;
  assign rsp_victim_dirty = r_rsp_valid & ~w_inv_found & w_set_dirty_bits[w_victim_way];
  assign rsp_victim_tag   = r_rsp_valid ? w_tag_q[w_victim_way] : '0;

endmodule
